// File: rtl/cycle_seq.sv
// rtl/cycle_seq.sv - machine-cycle STROB1/STROB2/GOT timing sequencer
//
// Purpose: on a cycle-start request, step through S1 -> [MW] -> [GAP -> S2]
// -> [HOLD] -> GOT. These phases clock the microinstruction flip-flops,
// counters and register-write strobes. Memory waits have a no-response
// timeout, and single-step mode parks the cycle in HOLD.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_start_cyc   cycle start request, sampled only in IDLE
//   i_long        long cycle (with STROB2), latched at start
//   i_mem_req     cycle performs a memory access, latched at start
//   i_mem_ok      memory acknowledge (level)
//   i_step_mode   single-step enable, latched at start
//   i_step        step key, a rising edge releases HOLD
//   o_strob1      high in S1
//   o_strob2      high in S2
//   o_got         high in GOT
//   o_busy        high in every state except IDLE
//   o_cycle_done  one-clock pulse on the last GOT clock
//   o_alarm       one-clock pulse on the last MW clock of a timeout
module cycle_seq #(
  parameter int S1_TICKS  = 3,
  parameter int GAP_TICKS = 2,
  parameter int S2_TICKS  = 3,
  parameter int GOT_TICKS = 2,
  parameter int TMO_TICKS = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start_cyc,
  input  logic i_long,
  input  logic i_mem_req,
  input  logic i_mem_ok,
  input  logic i_step_mode,
  input  logic i_step,
  output logic o_strob1,
  output logic o_strob2,
  output logic o_got,
  output logic o_busy,
  output logic o_cycle_done,
  output logic o_alarm
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_MW,
    ST_GAP,
    ST_S2,
    ST_HOLD,
    ST_GOT
  } state_t;

  // Terminal counts: a phase of N ticks exits when its counter holds N-1.
  localparam logic [7:0]  L_S1_LAST  = 8'(S1_TICKS - 1);
  localparam logic [7:0]  L_GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [7:0]  L_S2_LAST  = 8'(S2_TICKS - 1);
  localparam logic [7:0]  L_GOT_LAST = 8'(GOT_TICKS - 1);
  localparam logic [15:0] L_TMO_LAST = 16'(TMO_TICKS - 1);

  state_t      r_state;
  logic [7:0]  r_tick;
  logic [15:0] r_mw_cnt;
  logic        r_long;
  logic        r_mem_req;
  logic        r_step_mode;
  logic        r_ok_seen;
  logic        r_step_q;
  logic        r_strob1;
  logic        r_strob2;
  logic        r_got;
  logic        r_busy;
  logic        r_done;
  logic        r_tmo_last;

  state_t      w_state_nxt;
  state_t      w_post;
  logic        w_entry;
  logic        w_step_rise;
  logic [7:0]  w_tick_nxt;
  logic [15:0] w_mw_nxt;

  always_comb begin
    w_step_rise = i_step & ~r_step_q;
    // Where the cycle goes once STROB1 (and any memory wait) is over.
    if (r_long) begin
      w_post = ST_GAP;
    end else if (r_step_mode) begin
      w_post = ST_HOLD;
    end else begin
      w_post = ST_GOT;
    end

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start_cyc) begin
          w_state_nxt = ST_S1;
        end
      end
      ST_S1: begin
        if (r_tick == L_S1_LAST) begin
          // An acknowledge on this very edge counts as already seen.
          if (r_mem_req && !(r_ok_seen || i_mem_ok)) begin
            w_state_nxt = ST_MW;
          end else begin
            w_state_nxt = w_post;
          end
        end
      end
      ST_MW: begin
        if (i_mem_ok || (r_mw_cnt == L_TMO_LAST)) begin
          w_state_nxt = w_post;
        end
      end
      ST_GAP: begin
        if (r_tick == L_GAP_LAST) begin
          w_state_nxt = ST_S2;
        end
      end
      ST_S2: begin
        if (r_tick == L_S2_LAST) begin
          w_state_nxt = r_step_mode ? ST_HOLD : ST_GOT;
        end
      end
      ST_HOLD: begin
        if (w_step_rise) begin
          w_state_nxt = ST_GOT;
        end
      end
      ST_GOT: begin
        if (r_tick == L_GOT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // There are no self-transitions, so any state change is an entry.
    w_entry = (w_state_nxt != r_state);

    w_tick_nxt = r_tick;
    if (w_entry) begin
      w_tick_nxt = 8'd0;
    end else if ((r_state == ST_S1) || (r_state == ST_GAP) ||
                 (r_state == ST_S2) || (r_state == ST_GOT)) begin
      w_tick_nxt = r_tick + 8'd1;
    end

    w_mw_nxt = r_mw_cnt;
    if (w_entry) begin
      w_mw_nxt = 16'd0;
    end else if (r_state == ST_MW) begin
      w_mw_nxt = r_mw_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tick      <= 8'd0;
      r_mw_cnt    <= 16'd0;
      r_long      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_step_mode <= 1'b0;
      r_ok_seen   <= 1'b0;
      r_step_q    <= 1'b0;
      r_strob1    <= 1'b0;
      r_strob2    <= 1'b0;
      r_got       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tmo_last  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_mw_cnt <= w_mw_nxt;
      r_step_q <= i_step;

      if ((r_state == ST_IDLE) && i_start_cyc) begin
        r_long      <= i_long;
        r_mem_req   <= i_mem_req;
        r_step_mode <= i_step_mode;
        r_ok_seen   <= 1'b0;
      end else if (((r_state == ST_S1) || (r_state == ST_MW)) && i_mem_ok) begin
        r_ok_seen <= 1'b1;
      end

      // Outputs are decoded from the next state so they line up with it.
      r_strob1   <= (w_state_nxt == ST_S1);
      r_strob2   <= (w_state_nxt == ST_S2);
      r_got      <= (w_state_nxt == ST_GOT);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_GOT) && (w_tick_nxt == L_GOT_LAST);
      r_tmo_last <= (w_state_nxt == ST_MW) && (w_mw_nxt == L_TMO_LAST);
    end
  end

  assign o_strob1     = r_strob1;
  assign o_strob2     = r_strob2;
  assign o_got        = r_got;
  assign o_busy       = r_busy;
  assign o_cycle_done = r_done;
  // The alarm shows during the last MW clock. It is qualified with the live
  // acknowledge because a mem_ok arriving on that same clock still ends the
  // wait normally, and then no alarm is raised.
  assign o_alarm      = r_tmo_last & ~i_mem_ok;

endmodule

// File: tb/tb_cycle_seq.sv
// tb/tb_cycle_seq.sv - randomized trace-model bench for cycle_seq
module tb_cycle_seq;

  localparam int S1  = 3;
  localparam int GAP = 2;
  localparam int S2  = 3;
  localparam int GT  = 2;
  localparam int TMO = 10;
  localparam int N   = 128;

  logic clk = 1'b0;
  logic rst_n, start_cyc, long_i, mem_req, mem_ok, step_mode, step;
  logic strob1, strob2, got, busy, cycle_done, alarm;
  logic [5:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_seq #(
    .S1_TICKS(S1), .GAP_TICKS(GAP), .S2_TICKS(S2), .GOT_TICKS(GT), .TMO_TICKS(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_cyc(start_cyc), .i_long(long_i),
    .i_mem_req(mem_req), .i_mem_ok(mem_ok), .i_step_mode(step_mode), .i_step(step),
    .o_strob1(strob1), .o_strob2(strob2), .o_got(got), .o_busy(busy),
    .o_cycle_done(cycle_done), .o_alarm(alarm)
  );

  always #5 clk = ~clk;

  assign outs = {strob1, strob2, got, busy, cycle_done, alarm};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: build the stimulus, derive the expected output trace from the
  // phase lengths, then drive it and compare every clock.
  // mok_kind: 0 never, 1 random, 2 always, 3 high from mok_at on.
  // step_kind: 0 random, 1 held high, dropped at step_at, risen at step_at+1.
  task automatic run_cycle(input string nm, input bit lng, input bit mrq, input bit stp,
                           input int mok_kind, input int mok_at,
                           input int step_kind, input int step_at);
    logic [5:0] exp_o [N];
    bit mok [N];
    bit stv [N];
    bit strt [N];
    int t, e, m, d, len, h, rel;
    bit seen, tmo;

    for (int j = 0; j < N; j++) begin
      case (mok_kind)
        0:       mok[j] = 1'b0;
        1:       mok[j] = ($urandom % 6) == 0;
        2:       mok[j] = 1'b1;
        default: mok[j] = (j >= mok_at);
      endcase
      if (step_kind == 0) begin
        stv[j] = (j < 60) ? (($urandom % 3) == 0) : ((j % 2) == 1);
      end else begin
        stv[j] = (j != step_at);
      end
      exp_o[j] = 6'b000000;
    end

    t = 0;
    for (int k = 0; k < S1; k++) exp_o[t++] = 6'b100100;
    seen = 1'b0;
    for (int j = 1; j <= S1; j++) seen |= mok[j];
    if (mrq && !seen) begin
      e = t;
      m = TMO;
      tmo = 1'b1;
      for (int f = e + 1; f <= e + TMO; f++) begin
        if (mok[f]) begin
          m = f - e;
          tmo = 1'b0;
          break;
        end
      end
      for (int k = 0; k < m; k++) exp_o[t++] = 6'b000100;
      if (tmo) exp_o[e + TMO - 1] = 6'b000101;
    end
    if (lng) begin
      for (int k = 0; k < GAP; k++) exp_o[t++] = 6'b000100;
      for (int k = 0; k < S2; k++)  exp_o[t++] = 6'b010100;
    end
    if (stp) begin
      h = t;
      rel = N - 8;
      for (int g = h + 1; g < N; g++) begin
        if (stv[g] && !stv[g - 1]) begin
          rel = g;
          break;
        end
      end
      while (t < rel) exp_o[t++] = 6'b000100;
    end
    for (int k = 0; k < GT; k++) exp_o[t++] = 6'b001100;
    exp_o[t - 1] = 6'b001110;
    d = t;
    len = d + $urandom_range(1, 3);

    strt[0] = 1'b1;
    for (int j = 1; j < N; j++) strt[j] = (j <= d) ? (($urandom % 4) == 0) : 1'b0;

    start_cyc = strt[0];
    long_i    = lng;
    mem_req   = mrq;
    step_mode = stp;
    mem_ok    = mok[0];
    step      = stv[0];
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      if (j + 1 < len) begin
        start_cyc = strt[j + 1];
        long_i    = 1'($urandom);
        mem_req   = 1'($urandom);
        step_mode = 1'($urandom);
        mem_ok    = mok[j + 1];
        step      = stv[j + 1];
      end else begin
        start_cyc = 1'b0;
        mem_ok    = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s t%0d", nm, j), 32'(outs), 32'(exp_o[j]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_cyc = 1'b0; long_i = 1'b0; mem_req = 1'b0; mem_ok = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(outs), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cycle("short",       1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    run_cycle("long",        1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    run_cycle("mw ok7",      1'b0, 1'b1, 1'b0, 3, 7, 0, 0);
    run_cycle("mw ok early", 1'b0, 1'b1, 1'b0, 2, 0, 0, 0);
    run_cycle("mw timeout",  1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    run_cycle("mw ok last",  1'b0, 1'b1, 1'b0, 3, 13, 0, 0);
    run_cycle("hold held",   1'b1, 1'b0, 1'b1, 0, 0, 1, 20);
    run_cycle("hold short",  1'b0, 1'b1, 1'b1, 1, 0, 0, 0);

    // Reset in the middle of STROB2.
    start_cyc = 1'b1; long_i = 1'b1; mem_req = 1'b0; step_mode = 1'b0;
    @(posedge clk);
    #1;
    start_cyc = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre-reset strob2", 32'(outs), 32'h14);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset mid strob2", 32'(outs), 32'h0);
    rst_n = 1'b1;
    run_cycle("after reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

    for (int c = 0; c < 40; c++) begin
      run_cycle($sformatf("rnd%0d", c), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
